// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary MAC array: streams weights into
// the PEs one strobe at a time, then admits a counted activation burst and tracks it to the output.
module systolic_seq_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   cfg_start,
    input  logic                   run_start,
    input  logic [LEN_W-1:0]       run_len,
    input  logic                   w_valid,
    input  logic [31:0]            w_data,
    output logic                   w_ready,
    output logic [ROWS*COLS-1:0]   pe_load,
    output logic [31:0]            pe_matrix,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic                   feed_en,
    output logic                   res_valid,
    output logic                   res_last,
    output logic                   busy,
    output logic                   weights_ok,
    output logic                   done
);

    localparam int PE_N  = ROWS * COLS;
    localparam int IDX_W = (PE_N > 1) ? $clog2(PE_N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     w_idx_r;
    logic [LEN_W-1:0]     run_len_r;
    logic [LEN_W-1:0]     beat_cnt_r;
    logic [PIPE_LAT-1:0]  trk_v_r;
    logic [PIPE_LAT-1:0]  trk_l_r;
    logic [PIPE_LAT-1:0]  trk_v_next_s;
    logic [PIPE_LAT-1:0]  trk_l_next_s;
    logic [PE_N-1:0]      pe_load_r;
    logic [31:0]          pe_matrix_r;
    logic                 weights_ok_r;
    logic                 done_r;
    logic                 w_acc_s;
    logic                 w_last_s;
    logic                 x_ready_s;
    logic                 feed_s;
    logic                 beat_last_s;

    assign w_acc_s     = w_valid && (state_r == ST_LOAD);
    assign w_last_s    = (w_idx_r == IDX_W'(PE_N - 1));
    assign x_ready_s   = (state_r == ST_RUN) && (beat_cnt_r < run_len_r);
    assign feed_s      = x_valid && x_ready_s;
    // beat_cnt_r < run_len_r whenever a beat is accepted, so the increment cannot wrap
    assign beat_last_s = ((beat_cnt_r + LEN_W'(1)) == run_len_r);

    // The array cannot stall: the tracker shifts every cycle, bubbles enter as zeros
    assign trk_v_next_s = (trk_v_r << 1'b1) | PIPE_LAT'(feed_s);
    assign trk_l_next_s = (trk_l_r << 1'b1) | PIPE_LAT'(feed_s && beat_last_s);

    assign w_ready    = (state_r == ST_LOAD);
    assign x_ready    = x_ready_s;
    assign feed_en    = feed_s;
    assign res_valid  = trk_v_r[PIPE_LAT-1];
    assign res_last   = trk_l_r[PIPE_LAT-1];
    assign busy       = (state_r != ST_IDLE);
    assign pe_load    = pe_load_r;
    assign pe_matrix  = pe_matrix_r;
    assign weights_ok = weights_ok_r;
    assign done       = done_r;

    // In-flight beat tracker and the sticky weights-loaded flag
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            trk_v_r      <= '0;
            trk_l_r      <= '0;
            weights_ok_r <= 1'b0;
        end else begin
            trk_v_r <= trk_v_next_s;
            trk_l_r <= trk_l_next_s;
            if (pe_load_r[PE_N-1]) begin
                weights_ok_r <= 1'b1;
            end else begin
                weights_ok_r <= weights_ok_r;
            end
        end
    end

    // Main sequencer FSM with registered load strobe, weight word and done pulse
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            w_idx_r     <= '0;
            run_len_r   <= '0;
            beat_cnt_r  <= '0;
            pe_load_r   <= '0;
            pe_matrix_r <= 32'd0;
            done_r      <= 1'b0;
        end else begin
            pe_load_r <= '0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_r <= ST_LOAD;
                        w_idx_r <= '0;
                    end else if (run_start) begin
                        run_len_r  <= run_len;
                        beat_cnt_r <= '0;
                        state_r    <= (run_len == '0) ? ST_DRAIN : ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_acc_s) begin
                        pe_load_r   <= PE_N'(1'b1) << w_idx_r;
                        pe_matrix_r <= w_data;
                        w_idx_r     <= w_idx_r + IDX_W'(1);
                        state_r     <= w_last_s ? ST_IDLE : ST_LOAD;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (run_len_r == '0) begin
                        state_r <= ST_DRAIN;
                    end else if (feed_s) begin
                        beat_cnt_r <= beat_cnt_r + LEN_W'(1);
                        state_r    <= beat_last_s ? ST_DRAIN : ST_RUN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Finish as the final result leaves, so done lands the cycle after res_last
                    if (trk_v_next_s == '0) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: a cycle model predicts handshakes and pushes
// due-cycle entries for strobes, results and done; a negedge monitor pops and compares.
module tb_systolic_seq_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int LEN_W    = 16;
    localparam int PIPE_LAT = 8;
    localparam int PE_N     = ROWS * COLS;

    logic              clk       = 1'b0;
    logic              areset    = 1'b1;
    logic              cfg_start = 1'b0;
    logic              run_start = 1'b0;
    logic [LEN_W-1:0]  run_len   = 16'd0;
    logic              w_valid   = 1'b0;
    logic [31:0]       w_data    = 32'd0;
    logic              x_valid   = 1'b0;
    logic              w_ready;
    logic [PE_N-1:0]   pe_load;
    logic [31:0]       pe_matrix;
    logic              x_ready;
    logic              feed_en;
    logic              res_valid;
    logic              res_last;
    logic              busy;
    logic              weights_ok;
    logic              done;

    systolic_seq_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .areset(areset), .cfg_start(cfg_start), .run_start(run_start),
        .run_len(run_len), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .pe_load(pe_load), .pe_matrix(pe_matrix), .x_valid(x_valid), .x_ready(x_ready),
        .feed_en(feed_en), .res_valid(res_valid), .res_last(res_last), .busy(busy),
        .weights_ok(weights_ok), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asrt = 0;
    int n_fail = 0;

    typedef struct { int due; int idx; logic [31:0] data; } load_e_t;
    typedef struct { int due; logic last; } res_e_t;
    typedef enum { M_IDLE, M_LOAD, M_RUN, M_DRAIN } mst_t;

    load_e_t     load_q[$];
    res_e_t      res_q[$];
    int          done_q[$];
    load_e_t     le;
    res_e_t      re;
    mst_t        m_st = M_IDLE;
    int          m_widx = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    int          m_wok_at = 32'h7fffffff;
    logic        m_wok = 1'b0;
    logic [31:0] m_matrix = 32'd0;
    logic        exp_xr;
    logic        r_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare this cycle's outputs, then advance the model for the next cycle
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (areset) begin
                m_st = M_IDLE; m_widx = 0; m_len = 0; m_cnt = 0;
                m_wok = 1'b0; m_wok_at = 32'h7fffffff; m_matrix = 32'd0;
                load_q.delete(); res_q.delete(); done_q.delete();
                chk("rst_pe_load", 32'(pe_load), 32'd0);
                chk("rst_pe_matrix", pe_matrix, 32'd0);
                chk("rst_weights_ok", 32'(weights_ok), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_res_valid", 32'(res_valid), 32'd0);
                chk("rst_w_ready", 32'(w_ready), 32'd0);
                chk("rst_x_ready", 32'(x_ready), 32'd0);
            end else begin
                if (cyc >= m_wok_at) m_wok = 1'b1;
                chk("weights_ok", 32'(weights_ok), 32'(m_wok));
                if (load_q.size() > 0 && load_q[0].due == cyc) begin
                    le = load_q.pop_front();
                    chk("pe_load_strobe", 32'(pe_load), 32'd1 << le.idx);
                    m_matrix = le.data;
                end else begin
                    chk("pe_load_idle", 32'(pe_load), 32'd0);
                end
                chk("pe_matrix", pe_matrix, m_matrix);
                if (res_q.size() > 0 && res_q[0].due == cyc) begin
                    re = res_q.pop_front();
                    chk("res_valid_on", 32'(res_valid), 32'd1);
                    chk("res_last", 32'(res_last), 32'(re.last));
                end else begin
                    chk("res_valid_off", 32'(res_valid), 32'd0);
                    chk("res_last_off", 32'(res_last), 32'd0);
                end
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    void'(done_q.pop_front());
                    chk("done_pulse", 32'(done), 32'd1);
                end else begin
                    chk("done_idle", 32'(done), 32'd0);
                end
                exp_xr = (m_st == M_RUN) && (m_cnt < m_len);
                chk("w_ready", 32'(w_ready), 32'(m_st == M_LOAD));
                chk("x_ready", 32'(x_ready), 32'(exp_xr));
                chk("feed_en", 32'(feed_en), 32'(exp_xr && x_valid));
                chk("busy", 32'(busy), 32'(m_st != M_IDLE));
                case (m_st)
                    M_IDLE: begin
                        if (cfg_start) begin
                            m_st = M_LOAD; m_widx = 0;
                        end else if (run_start) begin
                            m_len = int'(run_len); m_cnt = 0;
                            if (run_len == 16'd0) begin
                                m_st = M_DRAIN;
                                done_q.push_back(cyc + 2);
                            end else begin
                                m_st = M_RUN;
                            end
                        end
                    end
                    M_LOAD: begin
                        if (w_valid) begin
                            load_q.push_back('{due: cyc + 1, idx: m_widx, data: w_data});
                            m_widx++;
                            if (m_widx == PE_N) begin
                                m_st = M_IDLE;
                                if (!m_wok) m_wok_at = cyc + 2;
                            end
                        end
                    end
                    M_RUN: begin
                        if (exp_xr && x_valid) begin
                            r_last = (m_cnt + 1 == m_len);
                            res_q.push_back('{due: cyc + PIPE_LAT, last: r_last});
                            m_cnt++;
                            if (r_last) begin
                                done_q.push_back(cyc + PIPE_LAT + 1);
                                m_st = M_DRAIN;
                            end
                        end
                    end
                    M_DRAIN: begin
                        if (done_q.size() > 0 && done_q[0] == cyc + 1) m_st = M_IDLE;
                    end
                    default: m_st = M_IDLE;
                endcase
            end
        end
    end

    // Directed stimulus
    initial begin
        tick(3);
        areset = 1'b0;
        tick(2);

        // full load, w_valid held high
        cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
        w_valid = 1'b1;
        for (int k = 0; k < PE_N; k++) begin
            w_data = 32'h0001_0000 * (k + 1);
            tick(1);
        end
        w_valid = 1'b0;
        tick(4);

        // load with w_valid toggling
        cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
        for (int i = 0; i < 2 * PE_N; i++) begin
            w_valid = (i % 2 == 0);
            w_data  = $urandom;
            tick(1);
        end
        w_valid = 1'b0;
        tick(4);

        // run_len = 5, continuous activations
        run_len = 16'd5; run_start = 1'b1; tick(1); run_start = 1'b0;
        x_valid = 1'b1;
        tick(20);
        x_valid = 1'b0;
        tick(2);

        // run_len = 3 with a 2-cycle bubble after the first beat
        run_len = 16'd3; run_start = 1'b1; tick(1); run_start = 1'b0;
        x_valid = 1'b1; tick(1);
        x_valid = 1'b0; tick(2);
        x_valid = 1'b1; tick(2);
        x_valid = 1'b0;
        tick(16);

        // run_len = 0
        run_len = 16'd0; run_start = 1'b1; tick(1); run_start = 1'b0;
        tick(5);

        // cfg_start and run_start together: load wins; run_start during load ignored
        run_len = 16'd4; cfg_start = 1'b1; run_start = 1'b1; tick(1);
        cfg_start = 1'b0; run_start = 1'b0;
        w_valid = 1'b1;
        for (int k = 0; k < PE_N; k++) begin
            w_data    = $urandom;
            run_start = (k == 3);
            cfg_start = (k == 5);
            tick(1);
        end
        run_start = 1'b0; cfg_start = 1'b0; w_valid = 1'b0;
        tick(3);

        // reset after 7 weights, then a fresh full load from index 0
        cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
        w_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            w_data = 32'h0000_0100 * (k + 1);
            tick(1);
        end
        w_valid = 1'b0;
        areset  = 1'b1;
        tick(2);
        areset  = 1'b0;
        tick(2);
        cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
        w_valid = 1'b1;
        for (int k = 0; k < PE_N; k++) begin
            w_data = 32'h00A0_0000 + k;
            tick(1);
        end
        w_valid = 1'b0;
        tick(4);

        // short run after the reload
        run_len = 16'd2; run_start = 1'b1; tick(1); run_start = 1'b0;
        x_valid = 1'b1; tick(3); x_valid = 1'b0;
        tick(14);

        chk("load_q_drained", 32'(load_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
